// File: rtl/uart_echo_responder.sv
// UART echo responder: receives 8N1 bytes, buffers them in a small circular FIFO,
// and retransmits them in arrival order on the TX line.
module uart_echo_responder #(
  parameter int CLK_CY_PER_BIT = 87,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_Rx_Serial,
  input  logic       i_Tx_Hold,
  output logic       o_Tx_Serial,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Dv,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done,
  output logic       o_Frame_Err,
  output logic       o_Overflow
);

  localparam int CNT_W  = $clog2(CLK_CY_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_CY_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLK_CY_PER_BIT - 1) / 2);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;

  // Synchronizer; r_rx_armed blocks start detection until the line has been seen high.
  logic r_rx_meta, r_rx_sync, r_rx_armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta  <= 1'b0;
      r_rx_sync  <= 1'b0;
      r_rx_armed <= 1'b0;
    end else begin
      r_rx_meta <= i_Rx_Serial;
      r_rx_sync <= r_rx_meta;
      if (r_rx_sync) r_rx_armed <= 1'b1;
    end
  end

  rx_state_t        r_rx_state, w_rx_state;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt;
  logic [2:0]       r_rx_idx, w_rx_idx;
  logic [7:0]       r_rx_shift, w_rx_shift;
  logic [7:0]       r_rx_byte, w_rx_byte;
  logic             r_rx_stop_ok, w_rx_stop_ok;
  logic             w_rx_dv, w_frame_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_idx     <= '0;
      r_rx_shift   <= '0;
      r_rx_byte    <= '0;
      r_rx_stop_ok <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_state;
      r_rx_cnt     <= w_rx_cnt;
      r_rx_idx     <= w_rx_idx;
      r_rx_shift   <= w_rx_shift;
      r_rx_byte    <= w_rx_byte;
      r_rx_stop_ok <= w_rx_stop_ok;
    end
  end

  always_comb begin
    w_rx_state   = r_rx_state;
    w_rx_cnt     = r_rx_cnt;
    w_rx_idx     = r_rx_idx;
    w_rx_shift   = r_rx_shift;
    w_rx_byte    = r_rx_byte;
    w_rx_stop_ok = r_rx_stop_ok;
    w_rx_dv      = 1'b0;
    w_frame_err  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_armed && !r_rx_sync) begin
          w_rx_state = RX_START;
          w_rx_cnt   = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_BIT) begin
          w_rx_cnt   = '0;
          w_rx_idx   = '0;
          w_rx_state = r_rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt   = '0;
          w_rx_shift = {r_rx_sync, r_rx_shift[7:1]};
          if (r_rx_idx == 3'd7) w_rx_state = RX_STOP;
          else                  w_rx_idx   = r_rx_idx + 1'b1;
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt     = '0;
          w_rx_stop_ok = r_rx_sync;
          if (r_rx_sync) w_rx_byte = r_rx_shift;
          w_rx_state   = RX_CLEANUP;
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
      RX_CLEANUP: begin
        w_rx_dv     = r_rx_stop_ok;
        w_frame_err = !r_rx_stop_ok;
        w_rx_state  = RX_IDLE;
      end
      default: w_rx_state = RX_IDLE;
    endcase
  end

  // Echo FIFO: the pop decision is registered-count based, so a byte pushed this
  // cycle can never be popped in the same cycle.
  logic [7:0]       r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0] r_fifo_count;
  logic             w_fifo_full, w_fifo_empty, w_push, w_push_ok, w_pop;

  assign w_fifo_full  = (r_fifo_count == OCC_FULL);
  assign w_fifo_empty = (r_fifo_count == '0);
  assign w_push       = w_rx_dv;
  assign w_push_ok    = w_push && (!w_fifo_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_fifo_mem[r_wr_ptr] <= r_rx_byte;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop)      r_fifo_count <= r_fifo_count + 1'b1;
      else if (!w_push_ok && w_pop) r_fifo_count <= r_fifo_count - 1'b1;
    end
  end

  tx_state_t        r_tx_state, w_tx_state;
  logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt;
  logic [2:0]       r_tx_idx, w_tx_idx;
  logic [7:0]       r_tx_data, w_tx_data;
  logic             w_tx_serial, w_tx_active, w_tx_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_data  <= '0;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_idx   <= w_tx_idx;
      r_tx_data  <= w_tx_data;
    end
  end

  always_comb begin
    w_tx_state  = r_tx_state;
    w_tx_cnt    = r_tx_cnt;
    w_tx_idx    = r_tx_idx;
    w_tx_data   = r_tx_data;
    w_tx_serial = 1'b1;
    w_tx_active = 1'b0;
    w_tx_done   = 1'b0;
    w_pop       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_fifo_empty && !i_Tx_Hold) begin
          w_pop      = 1'b1;
          w_tx_data  = r_fifo_mem[r_rd_ptr];
          w_tx_cnt   = '0;
          w_tx_state = TX_START;
        end
      end
      TX_START: begin
        w_tx_serial = 1'b0;
        w_tx_active = 1'b1;
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt   = '0;
          w_tx_idx   = '0;
          w_tx_state = TX_DATA;
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        w_tx_serial = r_tx_data[r_tx_idx];
        w_tx_active = 1'b1;
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt = '0;
          if (r_tx_idx == 3'd7) w_tx_state = TX_STOP;
          else                  w_tx_idx   = r_tx_idx + 1'b1;
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        w_tx_active = 1'b1;
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt   = '0;
          w_tx_state = TX_DONE;
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      TX_DONE: begin
        w_tx_done  = 1'b1;
        w_tx_state = TX_IDLE;
      end
      default: w_tx_state = TX_IDLE;
    endcase
  end

  // Outputs decode from async-reset state, so reset forces the line high at once.
  assign o_Tx_Serial = w_tx_serial;
  assign o_Tx_Active = w_tx_active;
  assign o_Tx_Done   = w_tx_done;
  assign o_Rx_Byte   = r_rx_byte;
  assign o_Rx_Dv     = w_rx_dv;
  assign o_Frame_Err = w_frame_err;
  assign o_Overflow  = w_push && w_fifo_full && !w_pop;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder: drives serial frames, decodes the echo
// line and compares against a queue of expected echoed bytes.
module tb_uart_echo_responder;
  localparam int BIT = 87;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       hold = 1'b0;
  logic       o_Tx_Serial, o_Rx_Dv, o_Tx_Active, o_Tx_Done, o_Frame_Err, o_Overflow;
  logic [7:0] o_Rx_Byte;

  always #5 clk = ~clk;

  uart_echo_responder #(.CLK_CY_PER_BIT(BIT), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_Rx_Serial(rx), .i_Tx_Hold(hold),
    .o_Tx_Serial(o_Tx_Serial), .o_Rx_Byte(o_Rx_Byte), .o_Rx_Dv(o_Rx_Dv),
    .o_Tx_Active(o_Tx_Active), .o_Tx_Done(o_Tx_Done), .o_Frame_Err(o_Frame_Err),
    .o_Overflow(o_Overflow)
  );

  int n_vec = 0, n_err = 0;
  logic [7:0] exp_q[$];
  int n_echo = 0, n_abort = 0, n_dv = 0, n_dv_plain = 0, n_ferr = 0, n_ovf = 0;
  logic [7:0] last_ovf_byte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RX-side event counters.
  initial forever begin
    @(posedge clk); #1;
    if (rst_n) begin
      if (o_Rx_Dv) begin
        n_dv++;
        if (!o_Overflow) n_dv_plain++;
      end
      if (o_Frame_Err) n_ferr++;
      if (o_Overflow) begin
        n_ovf++;
        last_ovf_byte = o_Rx_Byte;
      end
    end
  end

  // TX decoder: starts on the first low cycle, samples mid-bit, checks framing.
  initial begin : tx_mon
    logic [7:0] b;
    logic       start_v, stop_v;
    int         act_bad, k;
    bit         ab;
    logic [7:0] e;
    forever begin
      @(posedge clk); #1;
      if (rst_n && o_Tx_Serial === 1'b0) begin
        b = 8'h00; start_v = 1'b1; stop_v = 1'b0; act_bad = 0; ab = 0;
        for (int c = 0; c < 10 * BIT; c++) begin
          if (!rst_n) begin
            ab = 1;
            break;
          end
          if (o_Tx_Active !== 1'b1) act_bad++;
          if (c % BIT == BIT / 2) begin
            k = c / BIT;
            if (k == 0)      start_v  = o_Tx_Serial;
            else if (k <= 8) b[k-1]   = o_Tx_Serial;
            else             stop_v   = o_Tx_Serial;
          end
          @(posedge clk); #1;
        end
        if (ab) begin
          n_abort++;
          $display("tx frame aborted by reset");
        end else begin
          chk("tx_start_bit", start_v, 0);
          chk("tx_stop_bit", stop_v, 1);
          chk("tx_active_frame", act_bad, 0);
          chk("tx_done_pulse", o_Tx_Done, 1);
          chk("tx_active_after", o_Tx_Active, 0);
          chk("echo_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("echo_byte", b, e);
          end
          n_echo++;
          $display("echo frame %02h", b);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit good);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    if (good) begin
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (60) @(negedge clk);
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end
    $display("rx frame %02h stop_ok=%0d", b, good);
  endtask

  task automatic wait_echo(input int target, input int bound, input string tag);
    int c = 0;
    while (n_echo < target && c < bound) begin
      @(negedge clk);
      c++;
    end
    chk(tag, n_echo, target);
  endtask

  initial begin
    #(1000000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_dv, base_ferr, base_echo, base_ovf, low_cnt, c;
    logic [7:0] b;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_serial", o_Tx_Serial, 1);
    chk("rst_rx_byte", o_Rx_Byte, 8'h00);
    chk("rst_rx_dv", o_Rx_Dv, 0);
    chk("rst_tx_active", o_Tx_Active, 0);
    chk("rst_tx_done", o_Tx_Done, 0);
    chk("rst_frame_err", o_Frame_Err, 0);
    chk("rst_overflow", o_Overflow, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Good echo of 0x3F
    exp_q.push_back(8'h3F);
    send(8'h3F, 1);
    chk("echo_dv_count", n_dv, 1);
    chk("echo_rx_byte", o_Rx_Byte, 8'h3F);
    chk("echo_no_ferr", n_ferr, 0);
    wait_echo(1, 2000, "echo_3f_seen");

    // Start-bit glitch
    base_dv = n_dv; base_ferr = n_ferr; base_echo = n_echo; low_cnt = 0;
    rx = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_Tx_Serial !== 1'b1) low_cnt++;
    end
    rx = 1'b1;
    repeat (1500) begin
      @(negedge clk);
      if (o_Tx_Serial !== 1'b1) low_cnt++;
    end
    chk("glitch_no_dv", n_dv, base_dv);
    chk("glitch_no_ferr", n_ferr, base_ferr);
    chk("glitch_no_echo", n_echo, base_echo);
    chk("glitch_tx_low", low_cnt, 0);

    // Framing error on 0xA5
    send(8'hA5, 0);
    repeat (10) @(negedge clk);
    chk("ferr_pulse", n_ferr, base_ferr + 1);
    chk("ferr_rx_byte_kept", o_Rx_Byte, 8'h3F);
    chk("ferr_no_dv", n_dv, base_dv);
    repeat (1500) @(negedge clk);
    chk("ferr_no_echo", n_echo, base_echo);

    // Overflow and ordering with TX held
    base_dv = n_dv_plain; base_echo = n_echo; base_ovf = n_ovf;
    hold = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      if (i <= 4) exp_q.push_back(b);
      send(b, 1);
    end
    repeat (10) @(negedge clk);
    chk("ovf_dv_count", n_dv_plain, base_dv + 4);
    chk("ovf_pulse_count", n_ovf, base_ovf + 1);
    chk("ovf_byte", last_ovf_byte, 8'h05);
    chk("ovf_held_no_echo", n_echo, base_echo);
    chk("ovf_held_line_high", o_Tx_Serial, 1);
    hold = 1'b0;
    wait_echo(base_echo + 4, 4 * 900 + 500, "ovf_echo_count");

    // Back-to-back stream through the wrapping FIFO
    base_dv = n_dv; base_echo = n_echo; base_ovf = n_ovf;
    for (int i = 0; i < 10; i++) begin
      b = 8'(i * 37 + 5);
      exp_q.push_back(b);
      send(b, 1);
    end
    wait_echo(base_echo + 10, 2500, "wrap_echo_count");
    chk("wrap_dv_count", n_dv, base_dv + 10);
    chk("wrap_no_ovf", n_ovf, base_ovf);

    // Reset in the middle of an echo
    hold = 1'b1;
    send(8'hC3, 1);
    base_echo = n_echo; base_ferr = n_ferr;
    hold = 1'b0;
    c = 0;
    while (o_Tx_Active !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("rst_mid_tx_started", o_Tx_Active, 1);
    repeat (3 * BIT + 40) @(negedge clk);
    chk("rst_mid_pre_serial", o_Tx_Serial, 0);
    base_dv = n_dv;
    @(posedge clk); #2;
    rst_n = 1'b0;
    rx = 1'b0;
    #1;
    chk("rst_mid_serial_async", o_Tx_Serial, 1);
    chk("rst_mid_active", o_Tx_Active, 0);
    chk("rst_mid_rx_byte", o_Rx_Byte, 8'h00);
    chk("rst_mid_done", o_Tx_Done, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (2000) @(negedge clk);
    chk("rst_mid_no_stale_echo", n_echo, base_echo);
    chk("rst_mid_abort_seen", n_abort, 1);
    chk("rst_low_line_no_ferr", n_ferr, base_ferr);
    chk("rst_low_line_no_dv", n_dv, base_dv);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_echo_responder.md
UART_ECHO_RESPONDER -- requirements
Module: uart_echo_responder

Interface
REQ-001 SHALL have parameter CLK_CY_PER_BIT, default 87, clock cycles per serial bit; legal values are >= 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, echo buffer depth in bytes; legal values are powers of 2, >= 2.
REQ-003 SHALL have port i_clk, input, 1 bit, the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port i_Rx_Serial, input, 1 bit, asynchronous serial line in (idle high).
REQ-006 SHALL have port i_Tx_Hold, input, 1 bit; when high, no new transmit frame starts.
REQ-007 SHALL have port o_Tx_Serial, output, 1 bit, serial line out (idle high).
REQ-008 SHALL have port o_Rx_Byte, output, 8 bits, last good received byte.
REQ-009 SHALL have port o_Rx_Dv, output, 1 bit, one-cycle pulse when o_Rx_Byte updates.
REQ-010 SHALL have port o_Tx_Active, output, 1 bit, high while a frame is on o_Tx_Serial.
REQ-011 SHALL have port o_Tx_Done, output, 1 bit, one-cycle pulse after each stop bit.
REQ-012 SHALL have port o_Frame_Err, output, 1 bit, one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port o_Overflow, output, 1 bit, one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-014 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all RX decisions use the synchronized value.
REQ-015 SHALL implement an RX FSM with states IDLE, START, DATA, STOP, CLEANUP.
REQ-016 RX IDLE SHALL move to START when the synchronized line is low.
REQ-017 RX START SHALL re-sample the line after (CLK_CY_PER_BIT-1)/2 cycles: low -> DATA; high -> IDLE, treated as a glitch with no output pulse.
REQ-018 RX DATA SHALL sample 8 bits, LSB first, each sampled CLK_CY_PER_BIT cycles after the previous sample.
REQ-019 RX STOP SHALL sample the line CLK_CY_PER_BIT cycles after the last data sample.
REQ-020 If the stop sample is 1, the block SHALL: update o_Rx_Byte; pulse o_Rx_Dv in the CLEANUP cycle; push the byte into the FIFO in that same cycle.
REQ-021 If the stop sample is 0, the block SHALL pulse o_Frame_Err in CLEANUP, discard the byte, leave o_Rx_Byte unchanged, and make no FIFO push.
REQ-022 CLEANUP SHALL last exactly 1 cycle, then go to IDLE.
REQ-023 On a push while the FIFO is full with no pop in the same cycle, the block SHALL drop the new byte, pulse o_Overflow and keep FIFO contents intact.
REQ-024 On a simultaneous push and pop, both SHALL succeed, including when the FIFO is full; no overflow is flagged.
REQ-025 A pop from an empty FIFO SHALL be prevented, and there SHALL be no same-cycle bypass from push to pop.
REQ-026 The FIFO SHALL be circular, with wrap-around read and write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1.
REQ-027 SHALL implement a TX FSM with states IDLE, START, DATA, STOP, DONE.
REQ-028 TX IDLE SHALL pop one byte and enter START when the FIFO is non-empty and i_Tx_Hold is low.
REQ-029 i_Tx_Hold SHALL be sampled only in TX IDLE; a frame already in progress always completes.
REQ-030 TX START SHALL drive o_Tx_Serial=0 for CLK_CY_PER_BIT cycles.
REQ-031 TX DATA SHALL drive the 8 bits LSB first, CLK_CY_PER_BIT cycles each.
REQ-032 TX STOP SHALL drive o_Tx_Serial=1 for CLK_CY_PER_BIT cycles.
REQ-033 TX DONE SHALL pulse o_Tx_Done for 1 cycle, then go to IDLE, giving at least 1 idle-high cycle between frames.
REQ-034 o_Tx_Active SHALL be high exactly in START, DATA and STOP.
REQ-035 Echoed bytes SHALL leave o_Tx_Serial in the same order they were received.
REQ-036 The RX and TX paths SHALL operate concurrently and independently.

Reset
REQ-037 While i_rst_n=0, the block SHALL hold: o_Tx_Serial=1; o_Rx_Byte=0x00; o_Rx_Dv, o_Tx_Active, o_Tx_Done, o_Frame_Err and o_Overflow all 0; FIFO empty; both FSMs in IDLE; all counters 0.
REQ-038 Reset asserted mid-frame SHALL return o_Tx_Serial high immediately, without waiting for a clock edge, and SHALL discard partial RX and TX frames.
REQ-039 After reset release, RX SHALL ignore the line until it has been high for at least one synchronized sample; a low line at release produces no frame.

Verification
REQ-040 The bench SHALL cover good echo: serial 0x3F on i_Rx_Serial -> o_Rx_Dv pulse with o_Rx_Byte=0x3F, then a 0x3F frame on o_Tx_Serial of 10*87 cycles, with o_Tx_Active high throughout, followed by an o_Tx_Done pulse.
REQ-041 The bench SHALL cover the start glitch: i_Rx_Serial low for 20 cycles, then high -> no o_Rx_Dv, no o_Frame_Err, o_Tx_Serial stays 1.
REQ-042 The bench SHALL cover a framing error: 0xA5 sent with stop bit 0 -> o_Frame_Err pulse, o_Rx_Byte unchanged, no echo frame.
REQ-043 The bench SHALL cover overflow and ordering: i_Tx_Hold=1, then 5 bytes 0x01..0x05 -> 4 o_Rx_Dv pulses plus 1 o_Overflow pulse on 0x05; after i_Tx_Hold=0, echoes are 0x01, 0x02, 0x03, 0x04 in order.
REQ-044 The bench SHALL cover FIFO wrap-around: 10 bytes sent back-to-back with i_Tx_Hold=0 -> all 10 echoed in order, with no o_Overflow.
REQ-045 The bench SHALL cover reset mid-transmit: i_rst_n pulsed low during DATA of an echo -> o_Tx_Serial=1 within the same cycle, outputs at reset values, and no stale echo after release.
